// File: rtl/frame_tail_appender_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi4_stream_if: AXI4-Stream bundle (1-bit tuser) used by the frame extender path. Rev 1.0
// ----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 16,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tuser;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  output tready);
endinterface
`default_nettype wire

// File: rtl/frame_tail_appender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_tail_appender: 1-stage video slice that appends EXTRA_LINES blank lines after EOF. Rev 1.0
// ----------------------------------------------------------------------------
module frame_tail_appender #(
  parameter int FRAME_RES_X = 1920,
  parameter int EXTRA_LINES = 8,
  parameter int PX_WIDTH    = 10,
  parameter int BLANK_VALUE = 0,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i,
  input  logic          eof_i,
  axi4_stream_if.master video_o
);

  localparam int c_tdata_w  = ((PX_WIDTH + 7) / 8) * 8;
  localparam int c_keep_w   = c_tdata_w / 8;
  localparam int c_px_cnt_w = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int c_ln_cnt_w = (EXTRA_LINES > 0) ? $clog2(EXTRA_LINES + 1) : 1;

  localparam logic [c_px_cnt_w-1:0] c_px_last    = c_px_cnt_w'(FRAME_RES_X - 1);
  localparam logic [c_ln_cnt_w-1:0] c_ln_last    = c_ln_cnt_w'((EXTRA_LINES > 0) ? EXTRA_LINES - 1 : 0);
  localparam logic [PX_WIDTH-1:0]   c_blank_px   = PX_WIDTH'(BLANK_VALUE);
  localparam logic [c_tdata_w-1:0]  c_blank_data = c_tdata_w'(c_blank_px);

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    INSERT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [c_px_cnt_w-1:0]   px_cnt_q, px_cnt_d;
  logic [c_ln_cnt_w-1:0]   ln_cnt_q, ln_cnt_d;

  logic                    tvalid_q, tvalid_d;
  logic [c_tdata_w-1:0]    tdata_q, tdata_d;
  logic [c_keep_w-1:0]     tstrb_q, tstrb_d;
  logic [c_keep_w-1:0]     tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic [TID_WIDTH-1:0]    tid_q, tid_d;
  logic [TDEST_WIDTH-1:0]  tdest_q, tdest_d;

  logic slot_free;
  logic in_ready;
  logic px_last;
  logic ln_last;

  always_comb begin
    slot_free = !tvalid_q || video_o.tready;
    in_ready  = 1'b0;
    px_last   = (px_cnt_q == c_px_last);
    ln_last   = (ln_cnt_q == c_ln_last);
    state_d   = state_q;
    px_cnt_d  = px_cnt_q;
    ln_cnt_d  = ln_cnt_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tstrb_d   = tstrb_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    tid_d     = tid_q;
    tdest_d   = tdest_q;

    case (state_q)
      PASS: begin
        in_ready = slot_free;
        if (slot_free) begin
          tvalid_d = video_i.tvalid;
          tdata_d  = video_i.tdata;
          tstrb_d  = video_i.tstrb;
          tkeep_d  = video_i.tkeep;
          tlast_d  = video_i.tlast;
          tuser_d  = video_i.tuser;
          tid_d    = video_i.tid;
          tdest_d  = video_i.tdest;
          // Only a handshaken EOF beat that also closes a line starts the tail.
          if ((EXTRA_LINES > 0) && video_i.tvalid && eof_i && video_i.tlast) begin
            state_d = INSERT;
          end
        end
      end

      INSERT: begin
        if (slot_free) begin
          tvalid_d = 1'b1;
          tdata_d  = c_blank_data;
          tstrb_d  = '1;
          tkeep_d  = '1;
          tlast_d  = px_last;
          tuser_d  = 1'b0;
          tid_d    = '0;
          tdest_d  = '0;
          if (px_last) begin
            px_cnt_d = '0;
            if (ln_last) begin
              ln_cnt_d = '0;
              state_d  = PASS;
            end else begin
              ln_cnt_d = ln_cnt_q + c_ln_cnt_w'(1);
            end
          end else begin
            px_cnt_d = px_cnt_q + c_px_cnt_w'(1);
          end
        end
      end

      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= PASS;
      px_cnt_q <= '0;
      ln_cnt_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tid_q    <= '0;
      tdest_q  <= '0;
    end else begin
      state_q  <= state_d;
      px_cnt_q <= px_cnt_d;
      ln_cnt_q <= ln_cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
    end
  end

  assign video_i.tready = in_ready;
  assign video_o.tvalid = tvalid_q;
  assign video_o.tdata  = tdata_q;
  assign video_o.tstrb  = tstrb_q;
  assign video_o.tkeep  = tkeep_q;
  assign video_o.tlast  = tlast_q;
  assign video_o.tuser  = tuser_q;
  assign video_o.tid    = tid_q;
  assign video_o.tdest  = tdest_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_tail_appender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_tail_appender: randomized scoreboard bench for the tail appender (tail and slice configs). Rev 1.0
// ----------------------------------------------------------------------------
module tb_frame_tail_appender;

  localparam int X  = 4;
  localparam int XL = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        last;
    logic        user;
    logic [3:0]  id;
    logic [3:0]  dest;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_eof, b_eof;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(16)) a_in ();
  axi4_stream_if #(.TDATA_WIDTH(16)) a_out ();
  axi4_stream_if #(.TDATA_WIDTH(16)) b_in ();
  axi4_stream_if #(.TDATA_WIDTH(16)) b_out ();

  frame_tail_appender #(.FRAME_RES_X(X), .EXTRA_LINES(XL), .PX_WIDTH(10), .BLANK_VALUE('h2A5)) dut_a (
    .clk_i(clk), .rst_i(rst), .video_i(a_in), .eof_i(a_eof), .video_o(a_out));

  frame_tail_appender #(.FRAME_RES_X(X), .EXTRA_LINES(0), .PX_WIDTH(10), .BLANK_VALUE('h2A5)) dut_b (
    .clk_i(clk), .rst_i(rst), .video_i(b_in), .eof_i(b_eof), .video_o(b_out));

  int    n_cmp = 0;
  int    n_bad = 0;
  int    a_pops = 0;
  int    bp_mode = 0;
  beat_t qa[$];
  beat_t qb[$];
  logic  a_stall = 1'b0, b_stall = 1'b0;
  beat_t a_prev, b_prev, ai, ao, bi, bo, ex;
  logic  rdy_r = 1'b1;

  function automatic beat_t blank_beat(input int p);
    beat_t b;
    b.data = 16'h02A5;
    b.strb = 2'b11;
    b.keep = 2'b11;
    b.last = (p == X - 1);
    b.user = 1'b0;
    b.id   = 4'h0;
    b.dest = 4'h0;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = 16'($urandom);
    b.strb = 2'($urandom);
    b.keep = 2'($urandom);
    b.last = 1'($urandom);
    b.user = 1'($urandom);
    b.id   = 4'($urandom);
    b.dest = 4'($urandom);
    return b;
  endfunction

  // Output backpressure: 0 = always ready, 1 = toggle, 2 = random
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rdy_r = 1'b1;
      1:       rdy_r = ~rdy_r;
      default: rdy_r = 1'($urandom);
    endcase
    a_out.tready = rdy_r;
    b_out.tready = rdy_r;
  end

  // Reference model + scoreboard: accepted input beats (plus the blank tail after a
  // handshaken eof&tlast beat) form the expected output stream in order.
  always @(negedge clk) begin
    if (rst) begin
      a_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      ai = '{data:a_in.tdata, strb:a_in.tstrb, keep:a_in.tkeep, last:a_in.tlast,
             user:a_in.tuser, id:a_in.tid, dest:a_in.tdest};
      ao = '{data:a_out.tdata, strb:a_out.tstrb, keep:a_out.tkeep, last:a_out.tlast,
             user:a_out.tuser, id:a_out.tid, dest:a_out.tdest};
      bi = '{data:b_in.tdata, strb:b_in.tstrb, keep:b_in.tkeep, last:b_in.tlast,
             user:b_in.tuser, id:b_in.tid, dest:b_in.tdest};
      bo = '{data:b_out.tdata, strb:b_out.tstrb, keep:b_out.tkeep, last:b_out.tlast,
             user:b_out.tuser, id:b_out.tid, dest:b_out.tdest};

      if (a_in.tvalid && a_in.tready) begin
        qa.push_back(ai);
        if (a_eof && a_in.tlast)
          for (int l = 0; l < XL; l++)
            for (int p = 0; p < X; p++) qa.push_back(blank_beat(p));
      end
      if (b_in.tvalid && b_in.tready) qb.push_back(bi);

      if (a_stall) begin
        n_cmp++;
        if (!a_out.tvalid || ao !== a_prev) begin
          n_bad++;
          $display("FAIL hold_a: actual valid=%b beat=%h required valid=1 beat=%h", a_out.tvalid, ao, a_prev);
        end
      end
      if (b_stall) begin
        n_cmp++;
        if (!b_out.tvalid || bo !== b_prev) begin
          n_bad++;
          $display("FAIL hold_b: actual valid=%b beat=%h required valid=1 beat=%h", b_out.tvalid, bo, b_prev);
        end
      end

      if (a_out.tvalid && a_out.tready) begin
        a_pops++;
        n_cmp++;
        if (qa.size() == 0) begin
          n_bad++;
          $display("FAIL beat_a: actual=%h required=<no beat expected>", ao);
        end else begin
          ex = qa.pop_front();
          if (ao !== ex) begin
            n_bad++;
            $display("FAIL beat_a: actual=%h required=%h", ao, ex);
          end
        end
      end
      if (b_out.tvalid && b_out.tready) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_bad++;
          $display("FAIL beat_b: actual=%h required=<no beat expected>", bo);
        end else begin
          ex = qb.pop_front();
          if (bo !== ex) begin
            n_bad++;
            $display("FAIL beat_b: actual=%h required=%h", bo, ex);
          end
        end
      end

      a_stall = a_out.tvalid && !a_out.tready;
      b_stall = b_out.tvalid && !b_out.tready;
      a_prev  = ao;
      b_prev  = bo;
    end
  end

  task automatic present(input int which, input beat_t b, input logic eof, input logic valid);
    if (which == 0) begin
      a_in.tvalid = valid; a_in.tdata = b.data; a_in.tstrb = b.strb; a_in.tkeep = b.keep;
      a_in.tlast = b.last; a_in.tuser = b.user; a_in.tid = b.id; a_in.tdest = b.dest;
      a_eof = eof;
    end else begin
      b_in.tvalid = valid; b_in.tdata = b.data; b_in.tstrb = b.strb; b_in.tkeep = b.keep;
      b_in.tlast = b.last; b_in.tuser = b.user; b_in.tid = b.id; b_in.tdest = b.dest;
      b_eof = eof;
    end
  endtask

  // Idle cycle with junk fields and a random eof that must be ignored
  task automatic idle(input int which);
    present(which, rand_beat(), 1'($urandom), 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input beat_t b, input logic eof);
    int   t;
    logic rdy;
    while ($urandom_range(0, 3) == 0) idle(which);
    present(which, b, eof, 1'b1);
    t   = 0;
    rdy = 1'b0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      rdy = (which == 0) ? a_in.tready : b_in.tready;
      if (!rdy) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    if (rdy) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: actual=tready stuck low required=accept within 200 cycles (dut %0d)", which);
    end
    present(which, rand_beat(), 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int which, input int lines);
    beat_t b;
    logic  eof;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < X; p++) begin
        b      = rand_beat();
        b.user = (l == 0 && p == 0);
        b.last = (p == X - 1);
        eof    = (l == lines - 1 && p == X - 1) || (p != X - 1 && $urandom_range(0, 5) == 0);
        send(which, b, eof);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (qa.size() + qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual=%0d beats outstanding required=0", qa.size() + qb.size());
    end
  endtask

  task automatic check_zero(input int which);
    logic [30:0] v;
    if (which == 0)
      v = {a_out.tvalid, a_out.tdata, a_out.tstrb, a_out.tkeep, a_out.tlast, a_out.tuser, a_out.tid, a_out.tdest};
    else
      v = {b_out.tvalid, b_out.tdata, b_out.tstrb, b_out.tkeep, b_out.tlast, b_out.tuser, b_out.tid, b_out.tdest};
    n_cmp++;
    if (v !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_fields_%0d: actual=%h required=0", which, v);
    end
  endtask

  initial begin
    int base;
    int t;
    a_out.tready = 1'b1;
    b_out.tready = 1'b1;
    present(0, '0, 1'b0, 1'b0);
    present(1, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain frame, full-rate output
    bp_mode = 0;
    send_frame(0, 3);
    drain();

    // Same frame under 1/0 toggling backpressure
    bp_mode = 1;
    send_frame(0, 3);
    drain();

    // Next frame's SOF presented while the tail is still being inserted
    bp_mode = 0;
    send_frame(0, 3);
    send_frame(0, 3);
    drain();

    bp_mode = 2;
    repeat (6) send_frame(0, $urandom_range(1, 3));
    drain();

    // Reset in the middle of the tail, then a fresh frame with a full tail
    bp_mode = 0;
    send_frame(0, 3);
    base = a_pops;
    t    = 0;
    while (a_pops < base + 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (a_pops < base + 4) begin
      n_bad++;
      $display("FAIL tail_start: actual=%0d beats required=%0d", a_pops - base, 4);
    end
    #1;
    rst = 1'b1;
    #1;
    check_zero(0);
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(0, 3);
    drain();

    // Zero extra lines: plain register slice under random traffic
    bp_mode = 2;
    repeat (8) send_frame(1, $urandom_range(1, 3));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
